// File: rtl/snapshot_mem_bridge.sv
// Bridges narrow register accesses to wide memory entries through a snapshot buffer.
// Optional `SNAPSHOT_TIMEOUT_EN adds a memory-ack watchdog that answers with err.
module snapshot_mem_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_DATA_WIDTH = 128,
  parameter int MEM_ADDR_WIDTH = 1,
  parameter int ADDR_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      srst,
  input  logic                      req_vld,
  input  logic                      wr_en,
  input  logic                      rd_en,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  output logic                      ack_vld,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      err,
  output logic                      mem_req_vld,
  output logic                      mem_wr_en,
  output logic                      mem_rd_en,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [MEM_DATA_WIDTH-1:0] mem_wr_data,
  input  logic                      mem_ack_vld,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rd_data
);

  localparam int N  = MEM_DATA_WIDTH / DATA_WIDTH;
  localparam int SW = $clog2(N);

  typedef enum logic [1:0] {IDLE, MEM_WR, MEM_RD, ACK} state_t;

  state_t                    state, state_nxt;
  logic [DATA_WIDTH-1:0]     snap_buf [N];
  logic [SW-1:0]             sub;
  logic [MEM_ADDR_WIDTH-1:0] entry;
  logic [MEM_DATA_WIDTH-1:0] wr_pack;
  logic                      timeout_hit;
  logic                      unused_bits;

  assign sub         = addr[SW-1:0];
  assign entry       = addr[SW +: MEM_ADDR_WIDTH];
  assign unused_bits = &{1'b0, addr[ADDR_WIDTH-1:SW+MEM_ADDR_WIDTH]};

`ifdef SNAPSHOT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] tmo_cnt;
  logic          tmo_flag;

  assign timeout_hit = ((state == MEM_WR) || (state == MEM_RD)) && !mem_ack_vld &&
                       (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign err = (state == ACK) && tmo_flag;

  // Counter restarts whenever the FSM changes state, so it only measures the wait in a memory state.
  always_ff @(posedge clk) begin
    if (srst) begin
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else begin
      tmo_flag <= timeout_hit;
      if ((state_nxt != state) || ((state != MEM_WR) && (state != MEM_RD)))
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  localparam int unused_tmo = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // The committed entry is the buffered upper words plus the word arriving on the trigger write.
  always_comb begin
    wr_pack = '0;
    for (int i = 0; i < N; i++) wr_pack[i*DATA_WIDTH +: DATA_WIDTH] = snap_buf[i];
    wr_pack[DATA_WIDTH-1:0] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (srst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ack_vld   = 1'b0;
    case (state)
      IDLE: begin
        if (req_vld) begin
          if (wr_en)      state_nxt = (sub == '0) ? MEM_WR : ACK;
          else if (rd_en) state_nxt = (sub == '0) ? MEM_RD : ACK;
          else            state_nxt = ACK;
        end
      end
      MEM_WR, MEM_RD: begin
        if (mem_ack_vld || timeout_hit) state_nxt = ACK;
      end
      ACK: begin
        ack_vld   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // rd_data is only rewritten on the way into ACK so it holds between acks.
  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < N; i++) snap_buf[i] <= '0;
      rd_data     <= '0;
      mem_req_vld <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
    end else begin
      mem_req_vld <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_rd_en   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_vld) begin
            if (wr_en) begin
              if (sub != '0) begin
                snap_buf[sub] <= wr_data;
                rd_data       <= '0;
              end else begin
                snap_buf[0] <= wr_data;
                mem_wr_data <= wr_pack;
                mem_addr    <= entry;
                mem_req_vld <= 1'b1;
                mem_wr_en   <= 1'b1;
              end
            end else if (rd_en) begin
              if (sub != '0) begin
                rd_data <= snap_buf[sub];
              end else begin
                mem_addr    <= entry;
                mem_req_vld <= 1'b1;
                mem_rd_en   <= 1'b1;
              end
            end else begin
              rd_data <= '0;
            end
          end
        end
        MEM_WR: begin
          if (mem_ack_vld || timeout_hit) rd_data <= '0;
        end
        MEM_RD: begin
          if (mem_ack_vld) begin
            for (int i = 0; i < N; i++) snap_buf[i] <= mem_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
            rd_data <= mem_rd_data[DATA_WIDTH-1:0];
          end else if (timeout_hit) begin
            rd_data <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
